// File: rtl/y_ctrl_fsm.sv
// y_ctrl_fsm: multi-cycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB).
// Ports: clk, reset (async, active-high); ins/ins_valid/ins_ready instruction
// handshake; zero ALU flag (used in EXEC); op ALU operation; reg_write, alu_src,
// reg_dst, mem_read, mem_write, mem2reg datapath controls; pc_en/pc_sel PC
// commit; busy (state != IDLE); illegal trap pulse only with
// Y_CTRL_ILLEGAL_TRAP_EN defined (otherwise unsupported instructions run as NOP).
module y_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic        zero,
  output logic [2:0]  op,
  output logic        reg_write,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem2reg,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        busy
`ifdef Y_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4;
  localparam logic [2:0] C_ALU = 3'd0;
  localparam logic [2:0] C_ADDI = 3'd1;
  localparam logic [2:0] C_LW = 3'd2;
  localparam logic [2:0] C_SW = 3'd3;
  localparam logic [2:0] C_BEQ = 3'd4;
  localparam logic [2:0] C_J = 3'd5;
  localparam logic [2:0] C_BAD = 3'd6;
  logic [2:0] state_q, state_d;
  logic [5:0] opc_q, opc_d, fn_q, fn_d;
  logic [2:0] cls, alu_op;
  logic       accept, in_dec, in_exec, in_mem, in_wb;
  logic       unused_ins;
  // only opcode and funct steer control; register/immediate fields pass by
  assign unused_ins = ^ins[25:6];
  assign accept = ins_ready & ins_valid;
  assign opc_d = accept ? ins[31:26] : opc_q;
  assign fn_d = accept ? ins[5:0] : fn_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opc_q <= 6'd0;
      fn_q <= 6'd0;
    end else begin
      state_q <= state_d;
      opc_q <= opc_d;
      fn_q <= fn_d;
    end
  end
  // decoded straight from the captured word so op is valid already in DECODE
  // and stays put until the next accept; the reset word 0 decodes as C_BAD/000
  always_comb begin
    cls = C_BAD;
    alu_op = 3'b000;
    case (opc_q)
      6'h00: begin
        case (fn_q)
          6'h20: begin cls = C_ALU; alu_op = 3'b010; end
          6'h22: begin cls = C_ALU; alu_op = 3'b110; end
          6'h24: begin cls = C_ALU; alu_op = 3'b000; end
          6'h25: begin cls = C_ALU; alu_op = 3'b001; end
          6'h2A: begin cls = C_ALU; alu_op = 3'b111; end
          default: cls = C_BAD;
        endcase
      end
      6'h08: begin cls = C_ADDI; alu_op = 3'b010; end
      6'h23: begin cls = C_LW; alu_op = 3'b010; end
      6'h2B: begin cls = C_SW; alu_op = 3'b010; end
      6'h04: begin cls = C_BEQ; alu_op = 3'b110; end
      6'h02: cls = C_J;
      default: cls = C_BAD;
    endcase
  end
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = ins_valid ? S_DECODE : S_IDLE;
`ifdef Y_CTRL_ILLEGAL_TRAP_EN
      S_DECODE: state_d = (cls == C_BAD) ? S_IDLE : S_EXEC;
`else
      S_DECODE: state_d = S_EXEC;
`endif
      S_EXEC: state_d = (cls == C_BEQ || cls == C_J) ? S_IDLE :
                        (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
      S_MEM: state_d = (cls == C_LW) ? S_WB : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign in_dec = state_q == S_DECODE;
  assign in_exec = state_q == S_EXEC;
  assign in_mem = state_q == S_MEM;
  assign in_wb = state_q == S_WB;
  assign ins_ready = state_q == S_IDLE;
  assign busy = ~ins_ready;
  assign op = alu_op;
  assign reg_dst = busy & (cls == C_ALU);
  assign alu_src = busy & (cls == C_ADDI || cls == C_LW || cls == C_SW);
  assign mem2reg = busy & (cls == C_LW);
  assign mem_read = in_mem & (cls == C_LW);
  assign mem_write = in_mem & (cls == C_SW);
  // unsupported words reaching WB (NOP build) still commit PC+4 but never write
  assign reg_write = in_wb & (cls != C_BAD);
  assign pc_en = in_wb | mem_write | (in_exec & (cls == C_BEQ || cls == C_J));
  assign pc_sel = (in_exec & cls == C_J) ? 2'b10 :
                  (in_exec & cls == C_BEQ & zero) ? 2'b01 : 2'b00;
`ifdef Y_CTRL_ILLEGAL_TRAP_EN
  assign illegal = in_dec & (cls == C_BAD);
`else
  logic unused_dec;
  assign unused_dec = in_dec;
`endif
endmodule

// File: tb/tb_y_ctrl_fsm.sv
// tb_y_ctrl_fsm: scoreboard bench for y_ctrl_fsm with directed and random instructions.
module tb_y_ctrl_fsm;
  logic        clk = 0;
  logic        reset = 0;
  logic [31:0] ins = 0;
  logic        ins_valid = 0;
  logic        ins_ready;
  logic        zero = 0;
  logic [2:0]  op;
  logic        reg_write, alu_src, reg_dst, mem_read, mem_write, mem2reg, pc_en, busy;
  logic [1:0]  pc_sel;
  logic        ill;
  always #5 clk = ~clk;
  y_ctrl_fsm dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .zero(zero), .op(op), .reg_write(reg_write), .alu_src(alu_src), .reg_dst(reg_dst),
    .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg), .pc_en(pc_en),
    .pc_sel(pc_sel), .busy(busy)
`ifdef Y_CTRL_ILLEGAL_TRAP_EN
    , .illegal(ill)
`endif
  );
`ifndef Y_CTRL_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif
  typedef struct {
    int lat; logic [1:0] sel; logic [2:0] op;
    int rw; int mr; int mw;
    logic rdst; logic asrc; logic m2r; logic trap;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int errors = 0, checks = 0, cyc = 0, acc = 0, spurious = 0;
  int rw_n, mr_n, mw_n;
  logic inflight = 0, want_ready = 0, op_bad, rdy_bad;
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // instruction-level reference: what a whole instruction must produce
  function automatic exp_t model(input logic [31:0] w, input logic z);
    exp_t e;
    logic bad;
    e.lat = 3; e.sel = 2'b00; e.op = 3'b000; e.rw = 0; e.mr = 0; e.mw = 0;
    e.rdst = 0; e.asrc = 0; e.m2r = 0; e.trap = 0; bad = 0;
    case (w[31:26])
      6'h00: begin
        e.rw = 1; e.rdst = 1;
        case (w[5:0])
          6'h20: e.op = 3'b010;
          6'h22: e.op = 3'b110;
          6'h24: e.op = 3'b000;
          6'h25: e.op = 3'b001;
          6'h2A: e.op = 3'b111;
          default: bad = 1;
        endcase
      end
      6'h08: begin e.op = 3'b010; e.asrc = 1; e.rw = 1; end
      6'h23: begin e.op = 3'b010; e.asrc = 1; e.m2r = 1; e.rw = 1; e.mr = 1; e.lat = 4; end
      6'h2B: begin e.op = 3'b010; e.asrc = 1; e.mw = 1; end
      6'h04: begin e.op = 3'b110; e.lat = 2; e.sel = z ? 2'b01 : 2'b00; end
      6'h02: begin e.lat = 2; e.sel = 2'b10; end
      default: bad = 1;
    endcase
    if (bad) begin
      e.op = 3'b000; e.rw = 0; e.rdst = 0;
`ifdef Y_CTRL_ILLEGAL_TRAP_EN
      e.lat = 1; e.trap = 1;
`else
      e.lat = 3;
`endif
    end
    return e;
  endfunction
  // monitor: pops the expectation at accept, compares at pc_en / illegal
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      sb.delete(); inflight = 0; want_ready = 0;
    end else begin
      if (want_ready) begin
        chk("ready_after_commit", {30'd0, busy, ins_ready}, 32'd1);
        want_ready = 0;
      end
      if (inflight) begin
        if (op !== cur.op) op_bad = 1;
        if (ins_ready) rdy_bad = 1;
        rw_n += int'(reg_write); mr_n += int'(mem_read); mw_n += int'(mem_write);
        if (pc_en || ill) begin
          chk("latency", cyc - acc, cur.lat);
          chk("pc_en", {31'd0, pc_en}, {31'd0, ~cur.trap});
          chk("illegal", {31'd0, ill}, {31'd0, cur.trap});
          if (pc_en) chk("pc_sel", {30'd0, pc_sel}, {30'd0, cur.sel});
          chk("op_stable", {31'd0, op_bad}, 0);
          chk("ready_low_busy", {31'd0, rdy_bad}, 0);
          chk("reg_write_cnt", rw_n, cur.rw);
          chk("mem_read_cnt", mr_n, cur.mr);
          chk("mem_write_cnt", mw_n, cur.mw);
          chk("levels", {29'd0, reg_dst, alu_src, mem2reg}, {29'd0, cur.rdst, cur.asrc, cur.m2r});
          inflight = 0; want_ready = 1;
        end else if (cyc - acc > 8) begin
          chk("commit_timeout", 0, 1);
          inflight = 0;
        end
      end else begin
        if (reg_write | mem_read | mem_write | pc_en | ill) spurious++;
        if (ins_ready && ins_valid) begin
          if (sb.size() == 0) chk("unexpected_accept", 1, 0);
          else begin
            cur = sb.pop_front(); inflight = 1; acc = cyc;
            op_bad = 0; rdy_bad = 0; rw_n = 0; mr_n = 0; mw_n = 0;
          end
        end
      end
    end
  end
  // pre=1 holds the word on ins with ins_valid high while the previous one runs
  task automatic issue(input logic [31:0] w, input logic z, input int gap, input bit pre);
    int b = 0;
    while (!ins_ready && b < 30) begin
      ins = pre ? w : $urandom;
      ins_valid = pre ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1; b++;
    end
    if (!ins_ready) chk("ready_wait", {31'd0, ins_ready}, 1);
    repeat (gap) begin ins_valid = 0; ins = $urandom; @(posedge clk); #1; end
    ins = w; ins_valid = 1; zero = z;
    sb.push_back(model(w, z));
    @(posedge clk); #1;
    ins = $urandom; ins_valid = 1'($urandom_range(0, 1));
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, {31'd0, ins_ready}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_op"}, {29'd0, op}, 0);
    chk({tag, "_pc_sel"}, {30'd0, pc_sel}, 0);
    chk({tag, "_ctrl"}, {24'd0, reg_write, alu_src, reg_dst, mem_read, mem_write, mem2reg, pc_en, ill}, 0);
  endtask
  initial begin
    logic [31:0] r, w;
    int k;
    #2 reset = 1;
    #1 reset_checks("rst");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    issue(32'h00851020, 0, 0, 0);
    issue(32'h10850003, 1, 1, 0);
    issue(32'h10850003, 0, 0, 0);
    issue(32'h8C850004, 0, 0, 0);
    issue(32'hAC850004, 0, 0, 0);
    issue(32'h00851020, 0, 0, 1);
    issue(32'h00851020, 0, 0, 0);
    @(posedge clk); #3 reset = 1;
    #1 reset_checks("rst_exec");
    @(posedge clk); #1 reset_checks("rst_hold");
    reset = 0;
    issue(32'h00000001, 0, 0, 0);
    issue(32'h08000010, 1, 0, 0);
    issue(32'h20a50001, 0, 2, 0);
    issue(32'h00851022, 0, 0, 1);
    issue(32'h00851024, 0, 0, 0);
    issue(32'h00851025, 0, 0, 1);
    issue(32'h0085102A, 0, 0, 0);
    issue(32'hFC000000, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9); r = $urandom;
      case (k)
        1: w = {6'h08, r[25:0]};
        2: w = {6'h23, r[25:0]};
        3: w = {6'h2B, r[25:0]};
        4: w = {6'h04, r[25:0]};
        5: w = {6'h02, r[25:0]};
        6: w = {6'h00, r[25:6], 6'h21};
        7: w = {6'h3F, r[25:0]};
        default: w = {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
      endcase
      issue(w, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    ins_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("spurious_pulses", spurious, 0);
    chk("drained", {30'd0, inflight, sb.size() != 0}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/y_ctrl_fsm.md
Y_CTRL_FSM -- requirements
Module: y_ctrl_fsm

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Port ins, input, 32: MIPS instruction word; opcode ins[31:26], funct ins[5:0].
REQ-004 Port ins_valid, input, 1: ins is presented.
REQ-005 Port ins_ready, output, 1: block accepts ins this cycle.
REQ-006 Port zero, input, 1: ALU zero flag, sampled in EXEC only.
REQ-007 Port op, output, 3: ALU operation. 000 = and, 001 = or, 010 = add, 110 = sub, 111 = slt.
REQ-008 Ports reg_write, alu_src, reg_dst, mem_read, mem_write, mem2reg, output, 1 each: datapath controls.
REQ-009 Port pc_en, output, 1: one-cycle pulse that commits the PC update.
REQ-010 Port pc_sel, output, 2: next-PC source, valid when pc_en=1. 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 Port busy, output, 1: state is not IDLE.
REQ-012 Port illegal, output, 1: one-cycle pulse on an unsupported instruction; exists only when Y_CTRL_ILLEGAL_TRAP_EN is defined.

Function
REQ-013 The FSM SHALL have states IDLE, DECODE, EXEC, MEM and WB, with binary encoding 0 to 4.
REQ-014 In IDLE, ins_ready=1; ins_valid=1 SHALL capture ins into an internal register and move to DECODE. In every other state ins_ready=0.
REQ-015 DECODE SHALL last one cycle, register all controls from the captured ins, then move to EXEC.
REQ-016 Decode table:
- R-type (opcode 0x00), funct 0x20/0x22/0x24/0x25/0x2A: op = add/sub/and/or/slt; reg_dst=1; alu_src=0.
- addi 0x08: op = add; alu_src=1.
- lw 0x23: op = add; alu_src=1; mem2reg=1.
- sw 0x2B: op = add; alu_src=1.
- beq 0x04: op = sub.
- j 0x02: no ALU operation.
REQ-017 op SHALL hold a stable value from DECODE through the end of the instruction.
REQ-018 EXEC transitions:
- beq: pc_en=1 in EXEC, pc_sel=01 if zero=1 else 00, then IDLE.
- j: pc_en=1 in EXEC, pc_sel=10, then IDLE.
- lw, sw: go to MEM.
- R-type, addi: go to WB.
REQ-019 MEM transitions:
- lw: mem_read=1 for one cycle, then WB.
- sw: mem_write=1 for one cycle, pc_en=1, pc_sel=00, then IDLE.
REQ-020 WB SHALL pulse reg_write=1 and pc_en=1 with pc_sel=00, then return to IDLE.
REQ-021 Latency from the accept edge to the pc_en cycle: beq/j = 2, R-type/addi/sw = 3, lw = 4.
REQ-022 reg_write, mem_read, mem_write and pc_en SHALL each be high for at most one cycle per instruction; none SHALL be high in IDLE or DECODE.
REQ-023 A new instruction SHALL NOT be accepted until the cycle after pc_en, i.e. back in IDLE; ins_valid held high SHALL be accepted on that cycle with no bubble beyond IDLE.
REQ-024 Changes on ins or ins_valid outside IDLE SHALL have no effect.

Reset
REQ-025 reset=1 SHALL force state IDLE immediately (asynchronous), regardless of the clock.
REQ-026 Output values while reset is asserted:
- ins_ready=1.
- busy=0.
- op=000.
- pc_sel=00.
- All other outputs 0.
REQ-027 Reset mid-instruction SHALL abort it with no further reg_write, mem_write or pc_en pulse. The first accept SHALL occur on the first clock edge after reset deasserts with ins_valid=1.

Configuration
REQ-028 With Y_CTRL_ILLEGAL_TRAP_EN defined, an unsupported opcode or funct SHALL:
- pulse illegal=1 in DECODE;
- assert no reg_write, mem or pc_en;
- return to IDLE on the next cycle.
REQ-029 Without Y_CTRL_ILLEGAL_TRAP_EN, the illegal port is absent. An unsupported instruction SHALL be executed as a NOP (DECODE, EXEC, WB with reg_write=0, pc_en=1, pc_sel=00).

Verification
REQ-030 Reset, then ins=0x00851020 (add) with ins_valid=1 at cycle 0:
- op=010 from cycle 1;
- reg_write=1, reg_dst=1, pc_en=1 at cycle 3;
- ins_ready=1 at cycle 4.
REQ-031 beq ins=0x10850003:
- zero=1 in EXEC gives pc_en=1, pc_sel=01 at cycle 2 with op=110;
- repeated with zero=0, gives pc_sel=00.
REQ-032 lw ins=0x8C850004:
- mem_read=1 at cycle 3;
- reg_write=1, mem2reg=1, pc_en=1 at cycle 4.
REQ-033 sw ins=0xAC850004 followed by back-to-back add with ins_valid held high:
- mem_write=1, pc_en=1 at cycle 3;
- add accepted at cycle 4.
REQ-034 Assert reset during EXEC of an add:
- state=IDLE and all pulses 0 immediately;
- no reg_write occurs afterwards.
REQ-035 ins=0x00000001 (funct 0x01):
- with the macro, illegal=1 at cycle 1 and ins_ready=1 at cycle 2;
- without it, pc_en=1 at cycle 3 and reg_write stays 0.
